wall_control: RTL and testbench

Control path for the scrolling-wall game. It sequences the wall datapath once per frame: erase the wall, update its position, redraw it, then wait for the next frame. It owns the frame-rate divider and the pixel-sweep counters. It drives the datapath's `alu_select` and the VGA adapter's `plot` strobe. It sits between the top level (`go` from a key or switch) and the datapath/VGA adapter pair.

---
 rtl/wall_pkg.sv | 26 ++
 rtl/wall_control_if.sv | 40 ++++
 rtl/wall_control_frame_divider.sv | 27 ++
 rtl/wall_control.sv | 144 ++++++++++++++
 tb/tb_wall_control.sv | 227 ++++++++++++++++++++++
 5 files changed

// File: rtl/wall_pkg.sv
// Shared definitions for the scrolling-wall control path and datapath:
// datapath command encodings, controller state type and default geometry.
package wall_pkg;

  // alu_select encodings understood by the wall datapath
  localparam logic [1:0] ALU_UPDATE = 2'd0;
  localparam logic [1:0] ALU_DEL    = 2'd1;
  localparam logic [1:0] ALU_DRAW   = 2'd2;
  localparam logic [1:0] ALU_HOLD   = 2'd3;

  // Controller sequencing states
  typedef enum logic [2:0] {
    ST_IDLE,
    ST_WAIT_TICK,
    ST_DEL,
    ST_UPDATE,
    ST_DRAW,
    ST_DONE
  } wall_state_t;

  // Default geometry and frame rate (15 Hz at 50 MHz)
  localparam int DEF_FRAME_DIV  = 3333333;
  localparam int DEF_WALL_WIDTH = 10;
  localparam int DEF_SCREEN_H   = 120;

endpackage

// File: rtl/wall_control_if.sv
// Bundle between the wall controller and its surroundings: run enable in,
// datapath command / VGA plot strobe / sweep offsets / status out.
// Optional feature macro: WALL_CTRL_PAUSE_EN adds the pause input.
interface wall_control_if #(
  parameter int WALL_WIDTH = wall_pkg::DEF_WALL_WIDTH,
  parameter int SCREEN_H   = wall_pkg::DEF_SCREEN_H
) ();
  localparam int DX_W = (WALL_WIDTH > 1) ? $clog2(WALL_WIDTH) : 1;
  localparam int DY_W = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;

  logic            go;
`ifdef WALL_CTRL_PAUSE_EN
  logic            pause;
`endif
  logic [1:0]      alu_select;
  logic            plot;
  logic [DX_W-1:0] dx;
  logic [DY_W-1:0] dy;
  logic            busy;
  logic            frame_done;
  logic            overrun;

  // Controller side
  modport master (
`ifdef WALL_CTRL_PAUSE_EN
    input  pause,
`endif
    input  go,
    output alu_select, plot, dx, dy, busy, frame_done, overrun
  );

  // Top-level / datapath / VGA side
  modport slave (
`ifdef WALL_CTRL_PAUSE_EN
    output pause,
`endif
    output go,
    input  alu_select, plot, dx, dy, busy, frame_done, overrun
  );
endinterface

// File: rtl/wall_control_frame_divider.sv
// Free-running modulo-FRAME_DIV counter; tick is high for the single cycle
// in which the count sits at its last value.
module frame_divider #(
  parameter int FRAME_DIV = wall_pkg::DEF_FRAME_DIV
) (
  input  logic clk,
  input  logic resetn,
  output logic tick
);
  localparam int CW = (FRAME_DIV > 1) ? $clog2(FRAME_DIV) : 1;
  localparam logic [CW-1:0] LAST = CW'(FRAME_DIV - 1);

  logic [CW-1:0] r_count;

  // Count 0..FRAME_DIV-1 and wrap on compare-equal
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_count <= '0;
    end else if (r_count == LAST) begin
      r_count <= '0;
    end else begin
      r_count <= r_count + CW'(1);
    end
  end

  assign tick = (r_count == LAST);
endmodule

// File: rtl/wall_control.sv
// Wall control path: once per frame tick it erases the wall (DEL sweep),
// issues one UPDATE, redraws it (DRAW sweep) and pulses frame_done.
// Ticks that land while a frame is in flight are remembered (one deep);
// a further tick in that situation raises the sticky overrun flag.
// Optional feature macro: WALL_CTRL_PAUSE_EN (pause holds WAIT_TICK).
module wall_control #(
  parameter int FRAME_DIV  = wall_pkg::DEF_FRAME_DIV,
  parameter int WALL_WIDTH = wall_pkg::DEF_WALL_WIDTH,
  parameter int SCREEN_H   = wall_pkg::DEF_SCREEN_H
) (
  input  logic           clk,
  input  logic           resetn,
  wall_control_if.master bus
);
  import wall_pkg::*;

  localparam int DX_W = (WALL_WIDTH > 1) ? $clog2(WALL_WIDTH) : 1;
  localparam int DY_W = (SCREEN_H > 1) ? $clog2(SCREEN_H) : 1;
  localparam logic [DX_W-1:0] DX_LAST = DX_W'(WALL_WIDTH - 1);
  localparam logic [DY_W-1:0] DY_LAST = DY_W'(SCREEN_H - 1);

  wall_state_t     r_state;
  logic [1:0]      r_alu_select;
  logic            r_plot;
  logic [DX_W-1:0] r_dx;
  logic [DY_W-1:0] r_dy;
  logic            r_busy;
  logic            r_frame_done;
  logic            r_overrun;
  logic            r_pending;
  logic            w_tick;
  logic            w_hold;
  logic            w_sweep_end;

  frame_divider #(.FRAME_DIV(FRAME_DIV)) u_frame_divider (
    .clk    (clk),
    .resetn (resetn),
    .tick   (w_tick)
  );

`ifdef WALL_CTRL_PAUSE_EN
  assign w_hold = bus.pause;
`else
  assign w_hold = 1'b0;
`endif

  assign w_sweep_end = (r_dx == DX_LAST) && (r_dy == DY_LAST);

  // Frame sequencer with registered outputs, tick bookkeeping and sweep counters
  always_ff @(posedge clk or negedge resetn) begin
    if (!resetn) begin
      r_state      <= ST_IDLE;
      r_alu_select <= ALU_HOLD;
      r_plot       <= 1'b0;
      r_dx         <= '0;
      r_dy         <= '0;
      r_busy       <= 1'b0;
      r_frame_done <= 1'b0;
      r_overrun    <= 1'b0;
      r_pending    <= 1'b0;
    end else begin
      r_frame_done <= 1'b0;

      // Mid-frame ticks are queued one deep; busy is high exactly in those states
      if (w_tick && r_busy) begin
        if (r_pending) r_overrun <= 1'b1;
        r_pending <= 1'b1;
      end

      case (r_state)
        ST_IDLE: begin
          r_pending <= 1'b0;
          if (bus.go) r_state <= ST_WAIT_TICK;
        end

        ST_WAIT_TICK: begin
          if (!bus.go) begin
            r_state   <= ST_IDLE;
            r_pending <= 1'b0;
          end else if (w_hold) begin
            if (w_tick) begin
              if (r_pending) r_overrun <= 1'b1;
              r_pending <= 1'b1;
            end
          end else if (w_tick || r_pending) begin
            if (w_tick && r_pending) r_overrun <= 1'b1;
            r_pending    <= 1'b0;
            r_state      <= ST_DEL;
            r_alu_select <= ALU_DEL;
            r_plot       <= 1'b1;
            r_busy       <= 1'b1;
          end
        end

        ST_DEL, ST_DRAW: begin
          if (r_dx != DX_LAST) begin
            r_dx <= r_dx + DX_W'(1);
          end else begin
            r_dx <= '0;
            if (!w_sweep_end) r_dy <= r_dy + DY_W'(1);
            else              r_dy <= '0;
          end
          if (w_sweep_end) begin
            r_plot <= 1'b0;
            if (r_state == ST_DEL) begin
              r_state      <= ST_UPDATE;
              r_alu_select <= ALU_UPDATE;
            end else begin
              r_state      <= ST_DONE;
              r_alu_select <= ALU_HOLD;
              r_frame_done <= 1'b1;
            end
          end
        end

        ST_UPDATE: begin
          r_state      <= ST_DRAW;
          r_alu_select <= ALU_DRAW;
          r_plot       <= 1'b1;
        end

        ST_DONE: begin
          r_state <= ST_WAIT_TICK;
          r_busy  <= 1'b0;
        end

        default: begin
          r_state      <= ST_IDLE;
          r_alu_select <= ALU_HOLD;
          r_plot       <= 1'b0;
          r_busy       <= 1'b0;
        end
      endcase
    end
  end

  assign bus.alu_select = r_alu_select;
  assign bus.plot       = r_plot;
  assign bus.dx         = r_dx;
  assign bus.dy         = r_dy;
  assign bus.busy       = r_busy;
  assign bus.frame_done = r_frame_done;
  assign bus.overrun    = r_overrun;
endmodule

// File: tb/tb_wall_control.sv
// Bench for wall_control: two instances (FRAME_DIV 50 and 8) with a 2x3 wall.
// Expected per-cycle outputs are queued from the tick schedule and compared
// against the selected instance on the falling edge.
module tb_wall_control;
  import wall_pkg::*;

  localparam int W = 2;
  localparam int H = 3;
  localparam int N = W * H;

  typedef struct {
    int cyc;
    int alu;
    int plot;
    int dx;
    int dy;
    int busy;
    int fd;
  } exp_t;

  logic clk = 1'b0;
  logic resetn = 1'b0;
  logic go = 1'b0;
`ifdef WALL_CTRL_PAUSE_EN
  logic pause = 1'b0;
`endif
  int   sel = 0;
  int   cyc = 0;
  int   total = 0;
  int   bad = 0;
  exp_t sb_q[$];

  always #5 clk = ~clk;

  wall_control_if #(.WALL_WIDTH(W), .SCREEN_H(H)) if_a ();
  wall_control_if #(.WALL_WIDTH(W), .SCREEN_H(H)) if_b ();

  assign if_a.go = go;
  assign if_b.go = go;
`ifdef WALL_CTRL_PAUSE_EN
  assign if_a.pause = pause;
  assign if_b.pause = pause;
`endif

  wall_control #(.FRAME_DIV(50), .WALL_WIDTH(W), .SCREEN_H(H)) dut_a (
    .clk    (clk),
    .resetn (resetn),
    .bus    (if_a)
  );

  wall_control #(.FRAME_DIV(8), .WALL_WIDTH(W), .SCREEN_H(H)) dut_b (
    .clk    (clk),
    .resetn (resetn),
    .bus    (if_b)
  );

  task automatic check_val(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] obs(input int field);
    logic [31:0] v;
    v = '0;
    case (field)
      0: v = (sel == 0) ? 32'(if_a.alu_select) : 32'(if_b.alu_select);
      1: v = (sel == 0) ? 32'(if_a.plot)       : 32'(if_b.plot);
      2: v = (sel == 0) ? 32'(if_a.dx)         : 32'(if_b.dx);
      3: v = (sel == 0) ? 32'(if_a.dy)         : 32'(if_b.dy);
      4: v = (sel == 0) ? 32'(if_a.busy)       : 32'(if_b.busy);
      5: v = (sel == 0) ? 32'(if_a.frame_done) : 32'(if_b.frame_done);
      default: v = (sel == 0) ? 32'(if_a.overrun) : 32'(if_b.overrun);
    endcase
    return v;
  endfunction

  task automatic push(input int c, input int alu, input int plot, input int dx,
                      input int dy, input int busy, input int fd);
    exp_t e;
    e.cyc = c; e.alu = alu; e.plot = plot; e.dx = dx; e.dy = dy; e.busy = busy; e.fd = fd;
    sb_q.push_back(e);
  endtask

  // One full frame whose first DEL cycle is 'start', ending with the WAIT_TICK cycle
  task automatic push_frame(input int start);
    for (int i = 0; i < N; i++) push(start + i, 1, 1, i % W, i / W, 1, 0);
    push(start + N, 0, 0, 0, 0, 1, 0);
    for (int i = 0; i < N; i++) push(start + N + 1 + i, 2, 1, i % W, i / W, 1, 0);
    push(start + 2 * N + 1, 3, 0, 0, 0, 1, 1);
    push(start + 2 * N + 2, 3, 0, 0, 0, 0, 0);
  endtask

  task automatic push_idle(input int from, input int to);
    for (int c = from; c <= to; c++) push(c, 3, 0, 0, 0, 0, 0);
  endtask

  // Advance one clock and compare every expectation due at this cycle
  task automatic step();
    exp_t e;
    @(posedge clk);
    cyc++;
    @(negedge clk);
    while (sb_q.size() > 0 && sb_q[0].cyc <= cyc) begin
      e = sb_q.pop_front();
      check_val($sformatf("c%0d sched", cyc), 32'(cyc), 32'(e.cyc));
      check_val($sformatf("c%0d alu", cyc), obs(0), 32'(e.alu));
      check_val($sformatf("c%0d plot", cyc), obs(1), 32'(e.plot));
      check_val($sformatf("c%0d dx", cyc), obs(2), 32'(e.dx));
      check_val($sformatf("c%0d dy", cyc), obs(3), 32'(e.dy));
      check_val($sformatf("c%0d busy", cyc), obs(4), 32'(e.busy));
      check_val($sformatf("c%0d frame_done", cyc), obs(5), 32'(e.fd));
    end
  endtask

  task automatic run_to(input int n);
    while (cyc < n) step();
  endtask

  task automatic do_reset();
    @(negedge clk);
    resetn = 1'b0;
    repeat (2) @(negedge clk);
    sb_q.delete();
    cyc = 0;
    resetn = 1'b1;
  endtask

  task automatic check_reset_values(input string tag);
    check_val({tag, " alu"}, obs(0), 32'(ALU_HOLD));
    check_val({tag, " plot"}, obs(1), 0);
    check_val({tag, " dx"}, obs(2), 0);
    check_val({tag, " dy"}, obs(3), 0);
    check_val({tag, " busy"}, obs(4), 0);
    check_val({tag, " frame_done"}, obs(5), 0);
    check_val({tag, " overrun"}, obs(6), 0);
  endtask

  initial begin
    // Reset state
    sel = 0;
    repeat (2) @(negedge clk);
    check_reset_values("rst");

    // Basic frames: ticks at cycles 49 and 99
    go = 1'b1;
    do_reset();
    push_frame(50);
    push_frame(100);
    run_to(116);
    check_val("t1 overrun", obs(6), 0);
    $display("t1 basic frames done at cycle %0d", cyc);

    // go low for 200 cycles: nothing happens, no tick is remembered
    go = 1'b0;
    do_reset();
    push_idle(1, 200);
    run_to(200);
    check_val("t2 overrun", obs(6), 0);
    go = 1'b1;
    push_idle(201, 249);
    push_frame(250);
    $display("t2 idle hold done at cycle %0d", cyc);

    // go dropped at DRAW cycle 3: frame completes, then IDLE, no more DEL
    run_to(259);
    go = 1'b0;
    push_idle(265, 320);
    run_to(320);
    $display("t4 go drop done at cycle %0d", cyc);

    // Asynchronous reset at DEL cycle 4
    go = 1'b1;
    do_reset();
    push_frame(50);
    run_to(53);
    resetn = 1'b0;
    #1;
    check_reset_values("t5 async");
    @(negedge clk);
    sb_q.delete();
    cyc = 0;
    resetn = 1'b1;
    push_frame(50);
    run_to(65);
    $display("t5 async reset done at cycle %0d", cyc);

    // FRAME_DIV=8: pending starts frames back to back, second tick sets overrun
    sel = 1;
    go = 1'b1;
    do_reset();
    push_frame(8);
    push_frame(23);
    push_frame(38);
    push_frame(53);
    run_to(31);
    check_val("t3 overrun before", obs(6), 0);
    run_to(32);
    check_val("t3 overrun set", obs(6), 1);
    run_to(68);
    check_val("t3 overrun sticky", obs(6), 1);
    $display("t3 pending/overrun done at cycle %0d", cyc);

`ifdef WALL_CTRL_PAUSE_EN
    // Pause across two ticks, then release: DEL on the next cycle
    sel = 0;
    go = 1'b1;
    pause = 1'b1;
    do_reset();
    push_idle(1, 110);
    run_to(99);
    check_val("t6 overrun early", obs(6), 0);
    run_to(101);
    check_val("t6 overrun", obs(6), 1);
    run_to(110);
    pause = 1'b0;
    push_frame(111);
    run_to(126);
    $display("t6 pause done at cycle %0d", cyc);
`endif

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end
endmodule
